// File: rtl/snn_pkg.sv
// Shared types and defaults for the SNN per-neuron phase sequencer.
package snn_pkg;

  localparam int DEF_M     = 10;
  localparam int DEF_STEPS = 5000;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_GAP   = 4;
  localparam int DEF_TO_W  = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_W_PP1,
    S_LOAD,
    S_PP2,
    S_W_PP2,
    S_CHK,
    S_PP3,
    S_W_PP3M,
    S_W_WIN,
    S_W_PP3,
    S_TU,
    S_GAP,
    S_DONE
  } state_e;

  typedef struct packed {
    logic rdy;
    logic pp1;
    logic pp2;
    logic pp3;
    logic pp3m;
    logic won;
    logic tu;
    logic busy;
    logic done;
  } out_t;

  function automatic logic is_wait(input state_e s);
    return s inside {S_W_PP1, S_W_PP2, S_W_PP3M,
                     S_W_WIN, S_W_PP3};
  endfunction

endpackage

// File: rtl/snn_gap_timer.sv
// Loadable count-down timer; expired is high while the count is zero.
module snn_gap_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] ld_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = ld_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/snn_phase_sequencer.sv
// Sequences pot_adder through pp1/pp2/pp3/pp3m phases per timestep.
// Optional watchdog on W_* states: define SNN_SEQ_WATCHDOG_EN.
module snn_phase_sequencer
  import snn_pkg::*;
#(
  parameter int M     = DEF_M,
  parameter int STEPS = DEF_STEPS,
  parameter int CNT_W = DEF_CNT_W,
  parameter int GAP   = DEF_GAP,
  parameter int TO_W  = DEF_TO_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             spike_in_valid,
  input  logic [M-1:0]     spike_in,
  output logic             spike_in_ready,
  input  logic             valid_pp1,
  input  logic             valid_pp2,
  input  logic             valid_pp3m,
  input  logic             valid_pp3,
  input  logic             spike_pp,
  input  logic             win_valid,
  input  logic             win_hold,
  output logic [M-1:0]     spike_ip_nub,
  output logic             start_pp1,
  output logic             start_pp2,
  output logic             start_pp3,
  output logic             start_pp3m,
  output logic             won_lost_hold,
  output logic             TU_incre,
  output logic [CNT_W-1:0] step_cnt,
  output logic             busy,
  output logic             done,
  output logic             err_timeout
);

  localparam int GW = (GAP < 2) ? 1 : $clog2(GAP + 1);
  localparam logic [GW-1:0] GAP_LD =
    GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [CNT_W-1:0] STEPS_C = CNT_W'(STEPS);

  state_e           state_q, state_d, nxt;
  state_e           tgt_q, tgt_d;
  logic             fire_q, fire_d;
  logic [M-1:0]     nub_q, nub_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  out_t             out_q, out_d;
  logic             gap_exp, wd_to;

  function automatic state_e via_gap(input state_e t);
    return (GAP == 0) ? t : S_GAP;
  endfunction

  always_comb begin
    nxt    = state_q;
    tgt_d  = tgt_q;
    fire_d = fire_q;
    nub_d  = nub_q;
    cnt_d  = cnt_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (go) begin
        nxt   = S_INIT;
        cnt_d = '0;
      end
      S_INIT:  nxt = S_W_PP1;
      S_W_PP1: if (valid_pp1) begin
        nxt   = via_gap(S_LOAD);
        tgt_d = S_LOAD;
      end
      S_LOAD: if (spike_in_valid && out_q.rdy) begin
        nub_d = spike_in;
        nxt   = S_PP2;
      end
      S_PP2:   nxt = S_W_PP2;
      S_W_PP2: if (valid_pp2) begin
        fire_d = spike_pp;
        nxt    = S_CHK;
      end
      S_CHK:    nxt = fire_q ? S_PP3 : S_TU;
      S_PP3:    nxt = S_W_PP3M;
      S_W_PP3M: if (valid_pp3m) begin
        nxt   = via_gap(S_W_WIN);
        tgt_d = S_W_WIN;
      end
      S_W_WIN: if (win_valid) nxt = S_W_PP3;
      S_W_PP3: if (valid_pp3) nxt = S_TU;
      S_TU: if (cnt_q >= STEPS_C) begin
        nxt = S_DONE;
      end else begin
        nxt   = via_gap(S_LOAD);
        tgt_d = S_LOAD;
      end
      S_GAP:   if (gap_exp) nxt = tgt_q;
      default: nxt = S_IDLE;
    endcase
    // count moves with the TU_incre pulse, saturating at STEPS
    if (nxt == S_TU && state_q != S_TU && cnt_q < STEPS_C)
      cnt_d = cnt_q + CNT_W'(1);
  end

  assign state_d = wd_to ? S_IDLE : nxt;
  assign err_d   = err_q | wd_to;

  always_comb begin
    out_d      = '0;
    out_d.rdy  = (state_d == S_LOAD);
    out_d.pp1  = (state_d == S_INIT);
    out_d.pp2  = (state_d == S_PP2);
    out_d.pp3  = (state_d == S_PP3);
    out_d.pp3m = (state_q == S_W_WIN) && win_valid;
    out_d.won  = out_d.pp3m && win_hold;
    out_d.tu   = (state_d == S_TU);
    out_d.busy = !(state_d inside {S_IDLE, S_DONE});
    out_d.done = (state_d == S_DONE);
  end

  snn_gap_timer #(.W(GW)) u_gap (
    .clk     (clk),
    .rst     (rst),
    .load    ((state_d == S_GAP) && (state_q != S_GAP)),
    .ld_val  (GAP_LD),
    .en      (state_q == S_GAP),
    .expired (gap_exp)
  );

`ifdef SNN_SEQ_WATCHDOG_EN
  logic wd_exp;

  snn_gap_timer #(.W(TO_W)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .load    (is_wait(nxt) && (nxt != state_q)),
    .ld_val  ({TO_W{1'b1}} - TO_W'(1)),
    .en      (is_wait(state_q)),
    .expired (wd_exp)
  );

  assign wd_to = is_wait(state_q) && (nxt == state_q)
              && wd_exp;
`else
  // no watchdog: waits never time out
  assign wd_to = (TO_W < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tgt_q   <= S_IDLE;
      fire_q  <= 1'b0;
      nub_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      fire_q  <= fire_d;
      nub_q   <= nub_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      out_q   <= out_d;
    end
  end

  assign spike_in_ready = out_q.rdy;
  assign spike_ip_nub   = nub_q;
  assign start_pp1      = out_q.pp1;
  assign start_pp2      = out_q.pp2;
  assign start_pp3      = out_q.pp3;
  assign start_pp3m     = out_q.pp3m;
  assign won_lost_hold  = out_q.won;
  assign TU_incre       = out_q.tu;
  assign step_cnt       = cnt_q;
  assign busy           = out_q.busy;
  assign done           = out_q.done;
  assign err_timeout    = err_q;

endmodule

// File: tb/tb_snn_phase_sequencer.sv
// Scoreboard bench for snn_phase_sequencer (STEPS=3, GAP=4, TO_W=4).
module tb_snn_phase_sequencer;

  localparam int M     = 10;
  localparam int STEPS = 3;
  localparam int CNT_W = 16;
  localparam int GAP   = 4;
  localparam int TO_W  = 4;

  logic             clk = 1'b0;
  logic             rst, go, spike_in_valid;
  logic [M-1:0]     spike_in;
  logic             spike_in_ready;
  logic             valid_pp1, valid_pp2;
  logic             valid_pp3m, valid_pp3;
  logic             spike_pp, win_valid, win_hold;
  logic [M-1:0]     spike_ip_nub;
  logic             start_pp1, start_pp2;
  logic             start_pp3, start_pp3m;
  logic             won_lost_hold, TU_incre;
  logic [CNT_W-1:0] step_cnt;
  logic             busy, done, err_timeout;

  always #5 clk = ~clk;

  snn_phase_sequencer #(
    .M(M), .STEPS(STEPS), .CNT_W(CNT_W),
    .GAP(GAP), .TO_W(TO_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .go             (go),
    .spike_in_valid (spike_in_valid),
    .spike_in       (spike_in),
    .spike_in_ready (spike_in_ready),
    .valid_pp1      (valid_pp1),
    .valid_pp2      (valid_pp2),
    .valid_pp3m     (valid_pp3m),
    .valid_pp3      (valid_pp3),
    .spike_pp       (spike_pp),
    .win_valid      (win_valid),
    .win_hold       (win_hold),
    .spike_ip_nub   (spike_ip_nub),
    .start_pp1      (start_pp1),
    .start_pp2      (start_pp2),
    .start_pp3      (start_pp3),
    .start_pp3m     (start_pp3m),
    .won_lost_hold  (won_lost_hold),
    .TU_incre       (TU_incre),
    .step_cnt       (step_cnt),
    .busy           (busy),
    .done           (done),
    .err_timeout    (err_timeout)
  );

  typedef struct packed {
    logic [2:0]  kind;
    logic [15:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  n_vec = 0;
  int  n_bad = 0;
  bit  ok;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] k,
                      input logic [15:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic see(input logic [2:0] k,
                     input logic [15:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL unexpected_pulse: kind %0d data %0h, none expected",
               k, d);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("pulse_kind_exp%0d", e.kind),
          32'(k), 32'(e.kind));
      chk($sformatf("pulse_data_kind%0d", e.kind),
          32'(d), 32'(e.data));
    end
  endtask

  // Monitor: every output pulse is matched to the scoreboard
  always @(negedge clk) begin
    if (start_pp1 === 1'b1)  see(3'd1, 16'd0);
    if (start_pp2 === 1'b1)  see(3'd2, 16'(spike_ip_nub));
    if (start_pp3 === 1'b1)  see(3'd3, 16'd0);
    if (start_pp3m === 1'b1) see(3'd4, 16'(won_lost_hold));
    if (TU_incre === 1'b1)   see(3'd5, step_cnt);
  end

  function automatic logic pulse_of(input int k);
    case (k)
      1: return start_pp1;
      2: return start_pp2;
      3: return start_pp3;
      4: return start_pp3m;
      5: return TU_incre;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pulse(input int k);
    int n = 0;
    @(negedge clk);
    while (pulse_of(k) !== 1'b1 && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (pulse_of(k) !== 1'b1) begin
      n_vec++;
      n_bad++;
      $display("FAIL timeout_kind%0d: got no pulse expected pulse", k);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (spike_in_ready !== 1'b1 && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (spike_in_ready !== 1'b1) begin
      n_vec++;
      n_bad++;
      $display("FAIL timeout_ready: got 0 expected 1");
    end
  endtask

  task automatic start_run();
    push(3'd1, 16'd0);
    go = 1'b1;
    step();
    go = 1'b0;
    wait_pulse(1);
  endtask

  task automatic run_step(input logic [M-1:0] v,
                          input bit fire, input bit hold,
                          input int n, input bit abort,
                          input bit stray);
    wait_ready();
    push(3'd2, 16'(v));
    step();
    spike_in_valid = 1'b1;
    spike_in = v;
    step();
    spike_in_valid = 1'b0;
    spike_in = ~v;
    wait_pulse(2);
    step();
    if (stray) begin
      valid_pp3 = 1'b1;
      go = 1'b1;
      step();
      valid_pp3 = 1'b0;
      go = 1'b0;
    end
    if (!fire) push(3'd5, 16'(n));
    valid_pp2 = 1'b1;
    spike_pp = fire;
    step();
    valid_pp2 = 1'b0;
    spike_pp = 1'b0;
    if (fire) begin
      push(3'd3, 16'd0);
      wait_pulse(3);
      step();
      valid_pp3m = 1'b1;
      step();
      valid_pp3m = 1'b0;
      push(3'd4, 16'(hold));
      win_valid = 1'b1;
      win_hold = hold;
      wait_pulse(4);
      win_valid = 1'b0;
      @(negedge clk);
      chk("won_lost_hold_drop", 32'(won_lost_hold), 0);
      win_hold = 1'b0;
      if (abort) return;
      push(3'd5, 16'(n));
      step();
      valid_pp3 = 1'b1;
      step();
      valid_pp3 = 1'b0;
    end
    wait_pulse(5);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    go = 1'b0;
    spike_in_valid = 1'b0;
    spike_in = '0;
    valid_pp1 = 1'b0;
    valid_pp2 = 1'b0;
    valid_pp3m = 1'b0;
    valid_pp3 = 1'b0;
    spike_pp = 1'b0;
    win_valid = 1'b0;
    win_hold = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("reset_ctrl",
        32'({spike_in_ready, start_pp1, start_pp2,
             start_pp3, start_pp3m, won_lost_hold,
             TU_incre, busy, done, err_timeout}), 0);
    chk("reset_cnt", 32'(step_cnt), 0);
    chk("reset_nub", 32'(spike_ip_nub), 0);
    step();
    rst = 1'b0;

    start_run();
    chk("init_busy", 32'(busy), 1);
    step();
    step();
    step();
    valid_pp1 = 1'b1;
    step();
    valid_pp1 = 1'b0;
    for (int i = 0; i < GAP; i++) begin
      @(negedge clk);
      chk("gap_ready_low", 32'(spike_in_ready), 0);
    end
    @(negedge clk);
    chk("gap_ready_rise", 32'(spike_in_ready), 1);

    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (spike_in_ready !== 1'b1 || start_pp2 !== 1'b0)
        ok = 1'b0;
    end
    chk("backpressure_hold", 32'(ok), 1);

    run_step(10'b0000000101, 1'b0, 1'b0, 1, 1'b0, 1'b1);
    chk("nub_hold", 32'(spike_ip_nub), 32'h005);
    run_step(10'h2A1, 1'b1, 1'b1, 2, 1'b0, 1'b0);
    run_step(10'h3C0, 1'b1, 1'b0, 3, 1'b0, 1'b0);
    @(negedge clk);
    chk("done_flag", 32'(done), 1);
    chk("done_cnt", 32'(step_cnt), 3);
    chk("done_busy", 32'(busy), 0);
    repeat (5) @(negedge clk);
    chk("done_sticky", 32'(done), 1);
    chk("done_cnt_sat", 32'(step_cnt), 3);

    step();
    start_run();
    chk("restart_cnt", 32'(step_cnt), 0);
    chk("restart_done", 32'(done), 0);
    step();
    valid_pp1 = 1'b1;
    step();
    valid_pp1 = 1'b0;
    run_step(10'h155, 1'b1, 1'b1, 1, 1'b1, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    valid_pp3 = 1'b1;
    step();
    valid_pp3 = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_cnt", 32'(step_cnt), 0);
    chk("midrst_nub", 32'(spike_ip_nub), 0);
    chk("midrst_ready", 32'(spike_in_ready), 0);

`ifdef SNN_SEQ_WATCHDOG_EN
    step();
    start_run();
    step();
    valid_pp1 = 1'b1;
    step();
    valid_pp1 = 1'b0;
    wait_ready();
    push(3'd2, 16'h00F);
    step();
    spike_in_valid = 1'b1;
    spike_in = 10'h00F;
    step();
    spike_in_valid = 1'b0;
    wait_pulse(2);
    ok = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (err_timeout !== 1'b0 || busy !== 1'b1)
        ok = 1'b0;
    end
    chk("wd_wait", 32'(ok), 1);
    @(negedge clk);
    chk("wd_err", 32'(err_timeout), 1);
    chk("wd_idle", 32'(busy), 0);
    repeat (3) @(negedge clk);
    chk("wd_sticky", 32'(err_timeout), 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("wd_rst_clear", 32'(err_timeout), 0);
`endif

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
